buzzer_sched: RTL and testbench
===============================

# buzzer_sched

Time-driven scheduler and arbiter for the clock's single buzzer tone generator. It sequences the hourly strike chime, the alarm pattern and key-click beeps, then grants the tone generator to one source by fixed priority. Its `half_period`/`tone_on` outputs drive the existing square-wave ring generator, replacing ad-hoc tone selection in the time-keeping logic.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency.
- `BEEP_MS`, 100: key-beep duration in ms.
- `ALARM_SECS`, 60: alarm auto-timeout in seconds.
- `CHIME_HP`, 20'd113636: chime half-period in clk cycles (440 Hz).
- `ALARM_HP`, 20'd191131: alarm half-period (≈262 Hz).
- `BEEP_HP`, 20'd20000: beep half-period (2.5 kHz).

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `en` in 1: master sound enable.
- `tick_1hz` in 1: one-cycle pulse, seconds advanced; `hour`/`min`/`sec` already hold the new time.
- `hour` in 6: 0–23.
- `min` in 6: 0–59.
- `sec` in 6: 0–59.
- `alarm_hit` in 1: one-cycle pulse, alarm time matched.
- `alarm_stop` in 1: one-cycle pulse, user dismiss.
- `key_beep` in 1: one-cycle pulse, key pressed.
- `half_period` out 20: tone half-period to the ring generator; 0 when silent.
- `tone_on` out 1: buzzer enabled.
- `source` out 2: granted source. 00 none, 01 beep, 10 chime, 11 alarm.
- `strikes_left` out 4: chime strikes remaining, including the current one.
- `busy` out 1: any sequencer active (whether or not it is granted).

## Operation
- Three independent sequencers run concurrently. The arbiter grants by fixed priority: alarm > chime > beep. A masked sequencer keeps running; its time is lost, not deferred.
- **Chime FSM** (C_IDLE, C_ON, C_GAP):
  - Trigger: `tick_1hz` with `min==0`, `sec==0`, `hour<24`.
  - Load count = `hour mod 12`, with 0 mapped to 12. Go to C_ON.
  - C_ON on tick: if count==1, go to C_IDLE with count 0; otherwise go to C_GAP and decrement.
  - C_GAP on tick: go to C_ON.
  - Result: one strike per even second. Hour 3 sounds at seconds 0, 2, 4 and is idle from second 5.
  - `hour>=24` produces no chime.
  - A trigger while active reloads the count and enters C_ON.
- **Alarm**:
  - `alarm_hit` sets the active flag and clears a 6-bit elapsed counter.
  - Each tick increments elapsed. Tone sounds while `elapsed[0]==0`.
  - Ends when elapsed reaches `ALARM_SECS` or on `alarm_stop`.
  - `alarm_stop` and `alarm_hit` in the same cycle: stop wins.
  - `alarm_hit` while active restarts elapsed at 0.
- **Beep**:
  - `key_beep` loads a down-counter with `CLK_HZ/1000*BEEP_MS` cycles. Tone sounds while the counter is nonzero.
  - A retrigger reloads the counter.
  - Counter width is `$clog2` of the load value plus 1.
- **Output mux**: the winning source selects its `*_HP`. `tone_on` = winner present and in its sounding phase. A chime in C_GAP does not yield to beep.
- **en=0**:
  - All sequencers are forced idle and counters cleared.
  - All triggers are ignored; outputs go silent.
  - Re-enabling does not replay missed events.

## Timing
- All outputs are registered. They reflect sequencer state updated at sampling edge N on edge N+1, so latency from input pulse to output is 1 cycle.
- Reset values: `half_period` 0, `tone_on` 0, `source` 00, `strikes_left` 0, `busy` 0. All FSMs idle.
- `rst` asserted mid-chime or mid-alarm silences the outputs immediately (asynchronous). Sequencing resumes only on new triggers after release.
- Simultaneous `tick_1hz` and `alarm_hit`: both are processed in the same cycle. Alarm starts at elapsed 0; that tick does not increment it.
- The beep counter decrements every clk. It is independent of `tick_1hz`.

## Structure
- Package `buzzer_pkg`:
  - `source` encoding localparams (SRC_NONE/BEEP/CHIME/ALARM).
  - Chime state typedef.
  - Default half-period constants.
- One natural sub-module: `beep_timer`, a retriggerable one-shot down-counter with parameterised length. It is reused for the beep.
- Chime FSM, alarm counter and priority mux live in `buzzer_sched`.

## Test plan
- Reset, then `en=1` with no triggers → all outputs 0.
- Tick at 03:00:00, further ticks each second → `tone_on`=1, `source`=10, `half_period`=113636 during seconds 0, 2, 4. Silent at seconds 1 and 3. `strikes_left` reads 3, 3, 2, 2, 1, then 0 from second 5.
- Tick at 00:00:00 → 12 strikes, last at second 22. Tick at 24:00:00 → no chime.
- `alarm_hit` during a chime strike → next cycle `source`=11, `half_period`=191131. After `alarm_stop`, output returns to the running chime in its current phase.
- `key_beep` with `CLK_HZ`=1000, `BEEP_MS`=5 → `tone_on` high exactly 5 cycles, `half_period`=20000. Retrigger at cycle 3 extends to 8.
- Alarm unattended, `ALARM_SECS`=6 → sounds at elapsed 0, 2, 4; idle after the 6th tick. `rst` pulse mid-alarm → outputs 0 asynchronously and alarm does not resume.

Source files
------------

// File: rtl/buzzer_pkg.sv
// Shared encodings and default tone constants for the buzzer scheduler.
// Pure declarations; no logic, no latency, no backpressure.
package buzzer_pkg;

  localparam logic [1:0] SRC_NONE  = 2'b00;
  localparam logic [1:0] SRC_BEEP  = 2'b01;
  localparam logic [1:0] SRC_CHIME = 2'b10;
  localparam logic [1:0] SRC_ALARM = 2'b11;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_ON   = 2'd1,
    C_GAP  = 2'd2
  } chime_st_t;

  localparam logic [19:0] DEF_CHIME_HP = 20'd113636;
  localparam logic [19:0] DEF_ALARM_HP = 20'd191131;
  localparam logic [19:0] DEF_BEEP_HP  = 20'd20000;

  // 12-hour strike count: midnight and noon strike twelve times.
  function automatic logic [3:0] strike_count(input logic [5:0] hour);
    logic [5:0] h12;
    h12 = hour % 6'd12;
    return (h12 == 6'd0) ? 4'd12 : h12[3:0];
  endfunction

endpackage

// File: rtl/beep_timer.sv
// Retriggerable one-shot: active for LEN cycles after the last trigger.
// Latency: active rises the cycle after trig; no backpressure (trig always accepted).
module beep_timer #(
  parameter int LEN = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic trig,
  output logic active
);

  localparam int W = $clog2(LEN) + 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (trig) begin
      cnt <= W'(LEN);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign active = (cnt != '0);

endmodule

// File: rtl/buzzer_sched.sv
// Chime/alarm/beep sequencers with fixed-priority grant of the single tone generator.
// Outputs registered from sequencer state one edge later; triggers are pulses, never stalled.
module buzzer_sched
  import buzzer_pkg::*;
#(
  parameter int          CLK_HZ     = 100_000_000,
  parameter int          BEEP_MS    = 100,
  parameter int          ALARM_SECS = 60,
  parameter logic [19:0] CHIME_HP   = DEF_CHIME_HP,
  parameter logic [19:0] ALARM_HP   = DEF_ALARM_HP,
  parameter logic [19:0] BEEP_HP    = DEF_BEEP_HP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        tick_1hz,
  input  logic [5:0]  hour,
  input  logic [5:0]  min,
  input  logic [5:0]  sec,
  input  logic        alarm_hit,
  input  logic        alarm_stop,
  input  logic        key_beep,
  output logic [19:0] half_period,
  output logic        tone_on,
  output logic [1:0]  source,
  output logic [3:0]  strikes_left,
  output logic        busy
);

  chime_st_t   c_st;
  logic [3:0]  c_cnt;
  logic        a_act;
  logic [5:0]  a_el;
  logic [5:0]  a_el_inc;
  logic        b_act;
  logic        on_hour;

  assign on_hour  = tick_1hz && (min == 6'd0) && (sec == 6'd0) && (hour < 6'd24);
  assign a_el_inc = a_el + 6'd1;

  // Chime: strike on even seconds after the hour, one gap second between strikes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_st  <= C_IDLE;
      c_cnt <= 4'd0;
    end else if (!en) begin
      c_st  <= C_IDLE;
      c_cnt <= 4'd0;
    end else if (on_hour) begin
      c_st  <= C_ON;
      c_cnt <= strike_count(hour);
    end else if (tick_1hz) begin
      case (c_st)
        C_ON: begin
          if (c_cnt == 4'd1) begin
            c_st  <= C_IDLE;
            c_cnt <= 4'd0;
          end else begin
            c_st  <= C_GAP;
            c_cnt <= c_cnt - 4'd1;
          end
        end
        C_GAP:   c_st <= C_ON;
        default: c_st <= C_IDLE;
      endcase
    end
  end

  // Alarm: a tick coinciding with the hit starts at elapsed 0 without counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_act <= 1'b0;
      a_el  <= 6'd0;
    end else if (!en || alarm_stop) begin
      a_act <= 1'b0;
      a_el  <= 6'd0;
    end else if (alarm_hit) begin
      a_act <= 1'b1;
      a_el  <= 6'd0;
    end else if (a_act && tick_1hz) begin
      if (a_el_inc == 6'(ALARM_SECS)) begin
        a_act <= 1'b0;
        a_el  <= 6'd0;
      end else begin
        a_el <= a_el_inc;
      end
    end
  end

  beep_timer #(
    .LEN (CLK_HZ / 1000 * BEEP_MS)
  ) u_beep (
    .clk    (clk),
    .rst    (rst),
    .clr    (!en),
    .trig   (key_beep),
    .active (b_act)
  );

  logic [1:0]  src_nx;
  logic        on_nx;
  logic [19:0] hp_sel;

  always_comb begin
    src_nx = SRC_NONE;
    on_nx  = 1'b0;
    hp_sel = 20'd0;
    if (a_act) begin
      src_nx = SRC_ALARM;
      on_nx  = ~a_el[0];
      hp_sel = ALARM_HP;
    end else if (c_st != C_IDLE) begin
      // A chime in its gap still holds the grant, keeping the beep masked.
      src_nx = SRC_CHIME;
      on_nx  = (c_st == C_ON);
      hp_sel = CHIME_HP;
    end else if (b_act) begin
      src_nx = SRC_BEEP;
      on_nx  = 1'b1;
      hp_sel = BEEP_HP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_period  <= 20'd0;
      tone_on      <= 1'b0;
      source       <= SRC_NONE;
      strikes_left <= 4'd0;
      busy         <= 1'b0;
    end else begin
      half_period  <= on_nx ? hp_sel : 20'd0;
      tone_on      <= on_nx;
      source       <= src_nx;
      // The decrement happens on leaving a strike; the gap still counts the next one.
      strikes_left <= c_cnt + {3'd0, (c_st == C_GAP)};
      busy         <= a_act | (c_st != C_IDLE) | b_act;
    end
  end

endmodule

// File: tb/tb_buzzer_sched.sv
// Randomized bench for buzzer_sched against a time-based reference model.
// Model tracks ticks since the hour trigger, alarm seconds and beep cycles remaining.
module tb_buzzer_sched;
  import buzzer_pkg::*;

  localparam int CLK_HZ  = 1000;
  localparam int BEEP_MS = 5;
  localparam int ASECS   = 6;
  localparam int BLEN    = CLK_HZ / 1000 * BEEP_MS;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        tick_1hz;
  logic [5:0]  hour;
  logic [5:0]  min;
  logic [5:0]  sec;
  logic        alarm_hit;
  logic        alarm_stop;
  logic        key_beep;
  logic [19:0] half_period;
  logic        tone_on;
  logic [1:0]  source;
  logic [3:0]  strikes_left;
  logic        busy;

  buzzer_sched #(
    .CLK_HZ     (CLK_HZ),
    .BEEP_MS    (BEEP_MS),
    .ALARM_SECS (ASECS),
    .CHIME_HP   (20'd113636),
    .ALARM_HP   (20'd191131),
    .BEEP_HP    (20'd20000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .tick_1hz     (tick_1hz),
    .hour         (hour),
    .min          (min),
    .sec          (sec),
    .alarm_hit    (alarm_hit),
    .alarm_stop   (alarm_stop),
    .key_beep     (key_beep),
    .half_period  (half_period),
    .tone_on      (tone_on),
    .source       (source),
    .strikes_left (strikes_left),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit m_ch_on;
  int m_ch_n;
  int m_ch_t;
  bit m_al_on;
  int m_al_e;
  int m_bp;
  int en_low = 0;

  function automatic void model_reset();
    m_ch_on = 0; m_ch_n = 0; m_ch_t = 0;
    m_al_on = 0; m_al_e = 0;
    m_bp    = 0;
  endfunction

  function automatic void model_update();
    if (!en) begin
      model_reset();
      return;
    end
    if (tick_1hz && min == 0 && sec == 0 && hour < 24) begin
      m_ch_on = 1;
      m_ch_n  = (hour % 12 == 0) ? 12 : hour % 12;
      m_ch_t  = 0;
    end else if (tick_1hz && m_ch_on) begin
      m_ch_t++;
      if (m_ch_t >= 2 * m_ch_n - 1) m_ch_on = 0;
    end
    if (alarm_stop) begin
      m_al_on = 0; m_al_e = 0;
    end else if (alarm_hit) begin
      m_al_on = 1; m_al_e = 0;
    end else if (tick_1hz && m_al_on) begin
      m_al_e++;
      if (m_al_e >= ASECS) begin m_al_on = 0; m_al_e = 0; end
    end
    if (key_beep) m_bp = BLEN;
    else if (m_bp > 0) m_bp--;
  endfunction

  task automatic cycle();
    int e_src, e_hp, e_on, e_left, e_busy;
    e_src = 0; e_hp = 0; e_on = 0;
    if (m_al_on) begin
      e_src = 3; e_on = (m_al_e % 2 == 0); e_hp = e_on ? 191131 : 0;
    end else if (m_ch_on) begin
      e_src = 2; e_on = (m_ch_t % 2 == 0); e_hp = e_on ? 113636 : 0;
    end else if (m_bp > 0) begin
      e_src = 1; e_on = 1; e_hp = 20000;
    end
    e_left = m_ch_on ? (m_ch_n - m_ch_t / 2) : 0;
    e_busy = (m_al_on || m_ch_on || m_bp > 0) ? 1 : 0;
    model_update();
    @(posedge clk);
    #1;
    chk("source",       32'(source),       32'(e_src));
    chk("half_period",  32'(half_period),  32'(e_hp));
    chk("tone_on",      32'(tone_on),      32'(e_on));
    chk("strikes_left", 32'(strikes_left), 32'(e_left));
    chk("busy",         32'(busy),         32'(e_busy));
    tick_1hz = 0; alarm_hit = 0; alarm_stop = 0; key_beep = 0;
  endtask

  task automatic rand_events();
    alarm_hit  = ($urandom % 40) == 0;
    alarm_stop = ($urandom % 70) == 0;
    key_beep   = ($urandom % 12) == 0;
    if (en_low > 0) begin
      en = 0; en_low--;
    end else begin
      en = 1;
      if ($urandom % 250 == 0) en_low = $urandom_range(1, 6);
    end
  endtask

  task automatic advance_time();
    sec = (sec == 6'd59) ? 6'd0 : sec + 6'd1;
    if (sec == 0) begin
      min = (min == 6'd59) ? 6'd0 : min + 6'd1;
      if (min == 0) hour = hour + 6'd1;
    end
  endtask

  int hlist[6] = '{3, 0, 24, 12, 13, 1};

  initial begin
    rst = 1; en = 0; tick_1hz = 0; alarm_hit = 0; alarm_stop = 0; key_beep = 0;
    hour = 6'd5; min = 6'd1; sec = 6'd0;
    model_reset();
    #12;
    chk("rst_source",  32'(source),       32'd0);
    chk("rst_hp",      32'(half_period),  32'd0);
    chk("rst_tone",    32'(tone_on),      32'd0);
    chk("rst_strikes", 32'(strikes_left), 32'd0);
    chk("rst_busy",    32'(busy),         32'd0);
    @(negedge clk);
    rst = 0;
    en  = 1;
    for (int i = 0; i < 8; i++) cycle();

    for (int ep = 0; ep < 40; ep++) begin
      hour = (ep < 6) ? 6'(hlist[ep]) :
             (($urandom_range(0, 9) == 0) ? 6'($urandom_range(24, 63)) : 6'($urandom_range(0, 23)));
      min = 6'd0; sec = 6'd0;
      rand_events();
      if (ep == 1) alarm_hit = 1;
      tick_1hz = 1;
      cycle();
      for (int s = 0; s < 30; s++) begin
        int gap;
        gap = $urandom_range(1, 4);
        for (int g = 0; g < gap; g++) begin
          rand_events();
          cycle();
        end
        if (ep == 20 && s == 3) begin
          // Reset mid-alarm: outputs drop without waiting for a clock edge.
          alarm_hit = 1;
          cycle();
          cycle();
          #2;
          rst = 1;
          #1;
          chk("arst_tone",   32'(tone_on),     32'd0);
          chk("arst_source", 32'(source),      32'd0);
          chk("arst_hp",     32'(half_period), 32'd0);
          @(posedge clk);
          #1;
          rst = 0;
          model_reset();
          min = 6'd7;
        end
        advance_time();
        rand_events();
        tick_1hz = 1;
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
